fpf_codec_serial: RTL

Parametrised, iterative Fibonacci-numeral-system forbidden-pattern-free (FPF) codec. It resolves one code bit per clock, MSB first, and supports two per-transaction modes: encode (binary to N-bit FPF codeword) and decode (codeword to binary, with forbidden-pattern detection). It generalises the fixed-width, single-cycle FPF encoders to any width N, trading latency for area. It sits between the bus-word buffer and the crosstalk-avoidance link drivers/receivers, with valid/ready handshakes on both sides.

---
 rtl/fpf_codec_serial.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fpf_codec_serial.sv
// Bit-serial Fibonacci forbidden-pattern-free codec.
// One code bit per cycle, MSB first; encode and decode modes.
module fpf_codec_serial #(
  parameter int N = 33
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_err,
  output logic         out_mode
);

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a, b, t;
    a = 64'd1;
    b = 64'd1;
    for (int i = 2; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam logic [63:0] FTOP = fib(N + 2);
  localparam logic [63:0] FMAX = FTOP - 64'd1;
  localparam int DW = $clog2(FTOP);
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] fa_q, fa_d;
  logic [DW-1:0] fb_q, fb_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          prev_q, prev_d;
  logic          prev2_q, prev2_d;
  logic          err_q, err_d;
  logic          mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic          out_err_q, out_err_d;
  logic          out_mode_q, out_mode_d;
  logic          c;
  logic [63:0]   in_ext;

  always_comb begin
    state_d     = state_q;
    fa_d        = fa_q;
    fb_d        = fb_q;
    r_d         = r_q;
    acc_d       = acc_q;
    k_d         = k_q;
    sr_d        = sr_q;
    prev_d      = prev_q;
    prev2_d     = prev2_q;
    err_d       = err_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_mode_d  = out_mode_q;
    c           = 1'b0;
    in_ext      = 64'(in_data);
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          fa_d    = DW'(fib(N));
          fb_d    = DW'(fib(N + 1));
          k_d     = KW'(N - 1);
          r_d     = in_data[DW-1:0];
          acc_d   = '0;
          prev_d  = 1'b0;
          prev2_d = 1'b0;
          mode_d  = in_mode;
          sr_d    = in_mode ? in_data : '0;
          err_d   = !in_mode && (in_ext > FMAX);
        end
      end
      S_RUN: begin
        if (mode_q) begin
          c    = sr_q[N-1];
          sr_d = sr_q << 1;
          if (c) acc_d = acc_q + fa_q;
          // prev2/prev/c hold bits k+2, k+1, k
          if (int'(k_q) <= N - 3 &&
              ((prev2_q ^ prev_q) & (prev_q ^ c)))
            err_d = 1'b1;
        end else begin
          if (r_q < fa_q) c = 1'b0;
          else if (r_q >= fb_q) c = 1'b1;
          else c = prev_q;
          if (c) r_d = r_q - fa_q;
          sr_d = {sr_q[N-2:0], c};
        end
        prev2_d = prev_q;
        prev_d  = c;
        fb_d    = fa_q;
        fa_d    = fb_q - fa_q;
        k_d     = k_q - 1'b1;
        if (k_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_mode_d  = mode_q;
          out_err_d   = err_d;
          if (mode_q) out_data_d = N'(acc_d);
          else out_data_d = err_q ? '0 : sr_d;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fa_q        <= '0;
      fb_q        <= '0;
      r_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      sr_q        <= '0;
      prev_q      <= 1'b0;
      prev2_q     <= 1'b0;
      err_q       <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      sr_q        <= sr_d;
      prev_q      <= prev_d;
      prev2_q     <= prev2_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_mode_q  <= out_mode_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_mode  = out_mode_q;

endmodule
